// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS encoding definitions.
// The core control decoder uses the same op enum, opcode constants and funct
// constants, so the encoder and the decoder stay in step.
// encode() builds one 32-bit instruction word from an abstract op.
package mips_pkg;

    // Legal abstract ops. in_op[3] set means the op is illegal.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SLT = 3'd4,
        OP_LW  = 3'd5,
        OP_SW  = 3'd6,
        OP_BEQ = 3'd7
    } op_t;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    function automatic logic [31:0] encode(
        input op_t         op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm
    );
        logic [31:0] w;
        w = '0;
        case (op)
            OP_ADD: w = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD};
            OP_SUB: w = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUB};
            OP_AND: w = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_AND};
            OP_OR:  w = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_OR};
            OP_SLT: w = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SLT};
            OP_LW:  w = {OPC_LW, rs, rt, imm};
            OP_SW:  w = {OPC_SW, rs, rt, imm};
            OP_BEQ: w = {OPC_BEQ, rs, rt, imm};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO, DEPTH x WIDTH, first-word-fall-through head.
// Ports:
//   clk, reset    clock and synchronous active-high reset (empties the FIFO)
//   push, wdata   write an entry (caller guarantees !full)
//   pop           drop the head entry (caller guarantees !empty)
//   rdata         current head entry
//   full, empty   occupancy flags
//   count         current occupancy, 0..DEPTH
module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;

    // Storage needs no reset: rdata is only meaningful while !empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: accepts abstract ops over valid/ready, encodes them to
// MIPS words, buffers them in instr_fifo and streams them into imem.
// Ports:
//   clk, reset, clear    clock, sync active-high reset, sync soft clear (same effect)
//   in_valid/in_ready    op handshake; in_op/in_rs/in_rt/in_rd/in_imm op fields
//   finish               no more ops: drain the FIFO then report done
//   imem_we/addr/wdata   instruction memory write port; imem_stall holds it
//   words                number of words written so far
//   done                 drained after finish
//   mem_full             MEM_WORDS words written
//   err_illegal          sticky: an illegal op was accepted
module mips_instr_encoder
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MEM_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  in_op,
    input  logic [4:0]                  in_rs,
    input  logic [4:0]                  in_rt,
    input  logic [4:0]                  in_rd,
    input  logic [15:0]                 in_imm,
    input  logic                        finish,
    output logic                        imem_we,
    output logic [31:0]                 imem_addr,
    output logic [31:0]                 imem_wdata,
    input  logic                        imem_stall,
    output logic [$clog2(MEM_WORDS):0]  words,
    output logic                        done,
    output logic                        mem_full,
    output logic                        err_illegal
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned WW = $clog2(MEM_WORDS) + 1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_DRAIN,
        ST_FULL,
        ST_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic           flush;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [31:0]    fifo_head;
    logic [31:0]    enc_word;
    logic [WW:0]    outstanding;
    logic           accept;
    logic           legal;
    logic           push;
    logic           last_write;

    assign flush = reset | clear;

    // Words already written plus words still queued; one extra bit so the
    // sum cannot overflow before the compare against MEM_WORDS.
    assign outstanding = {1'b0, words} + (WW+1)'(fifo_count);

    assign in_ready = (state == ST_LOAD) && !fifo_full &&
                      (outstanding < (WW+1)'(MEM_WORDS)) && !finish;

    assign accept   = in_valid && in_ready;
    assign legal    = !in_op[3];
    assign push     = accept && legal;
    assign enc_word = encode(op_t'(in_op[2:0]), in_rs, in_rt, in_rd, in_imm);

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .reset (flush),
        .push  (push),
        .pop   (imem_we),
        .wdata (enc_word),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign imem_we    = !fifo_empty && !imem_stall &&
                        ((state == ST_LOAD) || (state == ST_DRAIN));
    assign imem_wdata = fifo_empty ? '0 : fifo_head;
    assign imem_addr  = BASE_ADDR + (32'(words) << 2);
    assign last_write = imem_we && (words == WW'(MEM_WORDS - 1));

    // FULL wins over both the finish transition and DONE on the same edge.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (last_write)  state_nxt = ST_FULL;
                else if (finish) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_write)      state_nxt = ST_FULL;
                else if (fifo_empty) state_nxt = ST_DONE;
            end
            ST_FULL:  state_nxt = ST_FULL;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state       <= ST_LOAD;
            words       <= '0;
            err_illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (imem_we) words <= words + 1'b1;
            if (accept && !legal) err_illegal <= 1'b1;
        end
    end

    assign done     = (state == ST_DONE);
    assign mem_full = (state == ST_FULL);

endmodule

// File: tb/tb_mips_instr_encoder.sv
module tb_mips_instr_encoder;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MEM_WORDS = 64;
    localparam logic [31:0] BASE_ADDR = 32'h0;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, finish, imem_stall;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic        in_ready, imem_we, done, mem_full, err_illegal;
    logic [31:0] imem_addr, imem_wdata;
    logic [6:0]  words;

    mips_instr_encoder #(
        .DEPTH     (DEPTH),
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_imm      (in_imm),
        .finish      (finish),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .imem_stall  (imem_stall),
        .words       (words),
        .done        (done),
        .mem_full    (mem_full),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: queue of encoded words waiting to be written.
    logic [31:0] pend[$];
    int  m_words = 0;
    bit  m_init = 0, m_drain = 0, m_done = 0, m_full = 0, m_err = 0, m_acc = 0;
    int  cyc = 0;

    // Observed writes.
    logic [31:0] log_addr [128];
    logic [31:0] log_data [128];
    int          log_cyc  [128];
    int          log_n = 0;

    function automatic logic [31:0] ref_encode(input int op, input int rs, input int rt,
                                               input int rd, input int imm);
        int unsigned r;
        r = (rs << 21) + (rt << 16);
        case (op)
            0: r = r + (rd << 11) + 32'h20;
            1: r = r + (rd << 11) + 32'h22;
            2: r = r + (rd << 11) + 32'h24;
            3: r = r + (rd << 11) + 32'h25;
            4: r = r + (rd << 11) + 32'h2A;
            5: r = r + (32'h23 << 26) + imm;
            6: r = r + (32'h2B << 26) + imm;
            default: r = r + (32'h04 << 26) + imm;
        endcase
        return r;
    endfunction

    function automatic bit exp_ready();
        return !m_drain && !m_done && !m_full && (pend.size() < DEPTH) &&
               (m_words + pend.size() < MEM_WORDS) && !finish;
    endfunction

    function automatic bit exp_we();
        return (pend.size() > 0) && !imem_stall && !m_done && !m_full;
    endfunction

    task automatic compare();
        if (imem_we === 1'b1 && log_n < 128) begin
            log_addr[log_n] = imem_addr;
            log_data[log_n] = imem_wdata;
            log_cyc[log_n]  = cyc;
            log_n++;
        end
        if (!m_init) return;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
        check("imem_we", {31'd0, imem_we}, {31'd0, exp_we()});
        check("words", {25'd0, words}, m_words);
        check("done", {31'd0, done}, {31'd0, m_done});
        check("mem_full", {31'd0, mem_full}, {31'd0, m_full});
        check("err_illegal", {31'd0, err_illegal}, {31'd0, m_err});
        if (exp_we()) begin
            check("imem_addr", imem_addr, BASE_ADDR + 4 * m_words);
            check("imem_wdata", imem_wdata, pend[0]);
        end
    endtask

    task automatic model_update();
        bit we, rdy, empty_before;
        m_acc = 0;
        if (reset || clear) begin
            pend.delete();
            m_words = 0;
            m_drain = 0; m_done = 0; m_full = 0; m_err = 0;
            m_init = 1;
            return;
        end
        if (!m_init) return;
        we  = exp_we();
        rdy = exp_ready();
        empty_before = (pend.size() == 0);
        if (we) begin
            void'(pend.pop_front());
            m_words++;
            if (m_words == MEM_WORDS) m_full = 1;
        end
        if (!m_full && !m_done) begin
            if (!m_drain) begin
                if (finish) m_drain = 1;
            end else if (empty_before) begin
                m_done = 1;
            end
        end
        if (rdy && in_valid) begin
            m_acc = 1;
            if (in_op < 8) pend.push_back(ref_encode(in_op, in_rs, in_rt, in_rd, in_imm));
            else m_err = 1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send_op(input int op, input int rs, input int rt, input int rd,
                           input int imm, output int acc_cyc);
        bit got;
        got = 0;
        acc_cyc = -1;
        in_valid = 1'b1;
        in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_imm = 16'(imm);
        for (int i = 0; i < 200 && !got; i++) begin
            cycle();
            got = m_acc;
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        log_n = 0;
    endtask

    int a;
    bit hit;

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; finish = 1'b0; imem_stall = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
        idle(2);
        reset = 1'b0;
        log_n = 0;
        cycle();
        check("reset_ready", {31'd0, in_ready}, 32'd1);
        check("reset_words", {25'd0, words}, 32'd0);

        // ADD rs=1 rt=2 rd=3: written the cycle after acceptance.
        send_op(0, 1, 2, 3, 0, a);
        idle(3);
        check("add_count", log_n, 1);
        check("add_addr", log_addr[0], 32'h0);
        check("add_data", log_data[0], 32'h00221820);
        check("add_latency", log_cyc[0], a);

        // LW then SW.
        do_clear();
        send_op(5, 0, 8, 0, 4, a);
        send_op(6, 29, 31, 0, 8, a);
        idle(4);
        check("lwsw_count", log_n, 2);
        check("lw_data", log_data[0], 32'h8C080004);
        check("lw_addr", log_addr[0], 32'h0);
        check("sw_data", log_data[1], 32'hAFBF0008);
        check("sw_addr", log_addr[1], 32'h4);

        // BEQ held by a 3-cycle stall.
        do_clear();
        imem_stall = 1'b1;
        send_op(7, 1, 2, 0, 16'hFFFF, a);
        idle(3);
        imem_stall = 1'b0;
        idle(3);
        check("beq_count", log_n, 1);
        check("beq_data", log_data[0], 32'h1022FFFF);
        check("beq_delay", log_cyc[0] - a, 3);

        // Illegal op dropped, following ADD still lands at address 0.
        do_clear();
        send_op(9, 4, 5, 6, 7, a);
        send_op(0, 1, 2, 3, 0, a);
        idle(3);
        check("illegal_err", {31'd0, err_illegal}, 32'd1);
        check("illegal_count", log_n, 1);
        check("illegal_addr", log_addr[0], 32'h0);
        check("illegal_next", log_data[0], 32'h00221820);

        // Fill the FIFO under stall, then release: 4 back-to-back writes.
        do_clear();
        imem_stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) send_op(i, i, i + 1, i + 2, 0, a);
        cycle();
        check("fifo_full_ready", {31'd0, in_ready}, 32'd0);
        imem_stall = 1'b0;
        idle(6);
        check("burst_count", log_n, DEPTH);
        for (int i = 1; i < DEPTH; i++) begin
            check("burst_b2b", log_cyc[i] - log_cyc[i-1], 1);
            check("burst_addr", log_addr[i], 4 * i);
        end

        // Stream MEM_WORDS ops to fill imem.
        do_clear();
        for (int i = 0; i < MEM_WORDS; i++)
            send_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 65535)), a);
        in_valid = 1'b1;
        cycle();
        check("stream_ready_low", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            hit = (mem_full === 1'b1);
        end
        check("mem_full_reached", {31'd0, hit}, 32'd1);
        check("stream_count", log_n, MEM_WORDS);
        check("stream_last_addr", log_addr[MEM_WORDS-1], 32'hFC);

        // Three ops then finish -> done.
        do_clear();
        for (int i = 0; i < 3; i++) send_op(i + 2, 3, 4, 5, 6, a);
        finish = 1'b1;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            hit = (done === 1'b1);
        end
        check("done_reached", {31'd0, hit}, 32'd1);
        check("done_count", log_n, 3);
        finish = 1'b0;
        do_clear();
        cycle();
        check("clear_words", {25'd0, words}, 32'd0);
        check("clear_ready", {31'd0, in_ready}, 32'd1);
        check("clear_done", {31'd0, done}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            in_valid   = ($urandom_range(0, 99) < 70);
            in_op      = ($urandom_range(0, 99) < 10) ? 4'(8 + $urandom_range(0, 7))
                                                      : 4'($urandom_range(0, 7));
            in_rs      = 5'($urandom);
            in_rt      = 5'($urandom);
            in_rd      = 5'($urandom);
            in_imm     = 16'($urandom);
            imem_stall = ($urandom_range(0, 99) < 30);
            finish     = ($urandom_range(0, 99) < 2);
            clear      = ($urandom_range(0, 99) < 2);
            reset      = ($urandom_range(0, 199) < 1);
            cycle();
        end
        reset = 1'b0; clear = 1'b0; finish = 1'b0; in_valid = 1'b0; imem_stall = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
